// File: rtl/ecc_ladder_ctrl_if.sv
// Bundle between the ECC top controller, the field multiplier and the
// ladder sequencer. The sequencer connects through the slave modport.
// The controller/multiplier side (or a bench) connects through master.
interface ecc_ladder_ctrl_if #(
    parameter int KW = 163
) ();
    logic          start;
    logic          abort;
    logic [KW-1:0] k;
    logic          m_done;
    logic          m_start;
    logic [2:0]    reg_select;
    logic          select_x;
    logic          select_xab;
    logic          select_z;
    logic          select_zab;
    logic          ss;
    logic          st;
    logic          sy;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output start, abort, k, m_done,
        input  m_start, reg_select, select_x, select_xab, select_z, select_zab,
        input  ss, st, sy, busy, done, err
    );

    modport slave (
        input  start, abort, k, m_done,
        output m_start, reg_select, select_x, select_xab, select_z, select_zab,
        output ss, st, sy, busy, done, err
    );
endinterface

// File: rtl/ecc_ladder_ctrl.sv
// Montgomery-ladder sequencer for binary-field ECC scalar multiplication.
// It scans the scalar for its leading one, then runs the init sequence and
// one ladder step per remaining bit. Each step emits operand selects,
// square/add enables and writeback codes, and handshakes with the
// external multiplier.
// Optional build macro ECC_LADDER_CONST_TIME_EN makes the scan always take
// KW cycles, so scan time does not leak the leading-one position.
module ecc_ladder_ctrl #(
    parameter int KW = 163,
    parameter int CW = $clog2(KW)
) (
    input  logic             clk,
    input  logic             rst_n,
    ecc_ladder_ctrl_if.slave bus
);

    typedef enum logic [4:0] {
        IDLE, SCAN, INIT0, INIT1, INIT2, INIT3, SWAP,
        M1, M2, S1, S2, M3, A1, S3, M4, A2, S4, M5, A3, UNSWAP, DONE
    } state_t;

    localparam logic [CW-1:0] IDX_TOP = CW'(KW - 1);

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [CW-1:0] idx_q, idx_d;      // bit currently being processed
    logic          lead0_q, lead0_d;  // leading one at bit 0: no ladder steps
    logic          wb_q, wb_d;        // multiply op is in its writeback cycle
    logic          zero_q, zero_d;    // scalar turned out to be zero
`ifdef ECC_LADDER_CONST_TIME_EN
    logic          found_q, found_d;  // a one has been seen during the scan
    logic [CW-1:0] lead_q, lead_d;    // position of the first one seen
`endif

    logic [6:0]    cw_q, cw_d;        // {select_x,select_xab,select_z,select_zab,ss,st,sy}
    logic [2:0]    rs_q, rs_d;
    logic          m_start_q, m_start_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    // Successor of each state inside one ladder step.
    function automatic state_t step_next(input state_t s);
        case (s)
            SWAP:    return M1;
            M1:      return M2;
            M2:      return S1;
            S1:      return S2;
            S2:      return M3;
            M3:      return A1;
            A1:      return S3;
            S3:      return M4;
            M4:      return A2;
            A2:      return S4;
            S4:      return M5;
            M5:      return A3;
            A3:      return UNSWAP;
            default: return IDLE;
        endcase
    endfunction

    function automatic logic is_mul(input state_t s);
        return (s == M1) || (s == M2) || (s == M3) || (s == M4) || (s == M5);
    endfunction

    function automatic logic [6:0] ctrl_word(input state_t s);
        case (s)
            INIT0:   return 7'b0010010;
            INIT1:   return 7'b1100101;
            INIT2:   return 7'b0010001;
            INIT3:   return 7'b1011010;
            M1:      return 7'b1110000;
            M2:      return 7'b1011000;
            M3:      return 7'b1000000;
            M4:      return 7'b1111000;
            M5:      return 7'b0011000;
            S1, S3:  return 7'b1000101;
            S2:      return 7'b0010001;
            A1:      return 7'b1000010;
            A2:      return 7'b1111010;
            S4:      return 7'b0011001;
            A3:      return 7'b1100010;
            default: return 7'b0000000;
        endcase
    endfunction

    // Register select for states whose code does not depend on k or the handshake.
    function automatic logic [2:0] fixed_rs(input state_t s);
        case (s)
            INIT0:   return 3'b001;
            INIT1:   return 3'b100;
            INIT2:   return 3'b010;
            INIT3:   return 3'b010;
            S1, S3:  return 3'b010;
            S2:      return 3'b101;
            A1:      return 3'b010;
            A2:      return 3'b011;
            S4:      return 3'b011;
            A3:      return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] wb_code(input state_t s);
        case (s)
            M1:      return 3'b001;
            M2:      return 3'b011;
            M3:      return 3'b100;
            M4:      return 3'b101;
            M5:      return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // Next-state logic plus decode of the outputs for the state being entered.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        idx_d   = idx_q;
        lead0_d = lead0_q;
        wb_d    = wb_q;
        zero_d  = zero_q;
`ifdef ECC_LADDER_CONST_TIME_EN
        found_d = found_q;
        lead_d  = lead_q;
`endif

        case (state_q)
            IDLE: begin
                idx_d   = IDX_TOP;
                lead0_d = 1'b0;
                wb_d    = 1'b0;
                zero_d  = 1'b0;
                if (bus.start) begin
                    k_d = bus.k;
`ifdef ECC_LADDER_CONST_TIME_EN
                    found_d = 1'b0;
                    lead_d  = '0;
                    state_d = SCAN;
`else
                    // The MSB is tested as start is accepted, so a scalar with
                    // its top bit set goes straight to the init sequence.
                    if (bus.k[KW-1]) begin
                        state_d = INIT0;
                        idx_d   = CW'(KW - 2);
                    end else begin
                        state_d = SCAN;
                    end
`endif
                end
            end

            SCAN: begin
`ifdef ECC_LADDER_CONST_TIME_EN
                // Every bit gets one cycle; the first one is only remembered.
                if (!found_q && k_q[idx_q]) begin
                    found_d = 1'b1;
                    lead_d  = idx_q;
                end
                if (idx_q == '0) begin
                    if (found_q || k_q[0]) begin
                        state_d = INIT0;
                        lead0_d = !found_q;
                        idx_d   = found_q ? (lead_q - CW'(1)) : '0;
                    end else begin
                        state_d = DONE;
                        zero_d  = 1'b1;
                    end
                end else begin
                    idx_d = idx_q - CW'(1);
                end
`else
                // Bits above idx are known zero; this cycle tests bit idx-1.
                // The cycle at idx 0 has nothing left to test: scalar is zero.
                if (idx_q == '0) begin
                    state_d = DONE;
                    zero_d  = 1'b1;
                end else if (k_q[idx_q - CW'(1)]) begin
                    state_d = INIT0;
                    lead0_d = (idx_q == CW'(1));
                    idx_d   = idx_q - CW'(1) - CW'(1);
                end else begin
                    idx_d = idx_q - CW'(1);
                end
`endif
            end

            INIT0: state_d = INIT1;
            INIT1: state_d = INIT2;
            INIT2: state_d = INIT3;
            INIT3: state_d = lead0_q ? DONE : SWAP;

            SWAP, S1, S2, A1, S3, A2, S4, A3: state_d = step_next(state_q);

            M1, M2, M3, M4, M5: begin
                if (!wb_q) begin
                    if (bus.m_done) begin
                        wb_d = 1'b1;
                    end
                end else begin
                    wb_d    = 1'b0;
                    state_d = step_next(state_q);
                end
            end

            UNSWAP: begin
                if (idx_q == '0) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q - CW'(1);
                    state_d = SWAP;
                end
            end

            DONE: begin
                state_d = IDLE;
                idx_d   = IDX_TOP;
                zero_d  = 1'b0;
            end

            default: state_d = IDLE;
        endcase

        // Abort beats everything, including a multiplier completion this cycle.
        if (bus.abort) begin
            state_d = IDLE;
            idx_d   = IDX_TOP;
            lead0_d = 1'b0;
            wb_d    = 1'b0;
            zero_d  = 1'b0;
        end

        cw_d = ctrl_word(state_d);
        if ((state_d == SWAP) || (state_d == UNSWAP)) begin
            rs_d = {2'b11, k_d[idx_d]};
        end else if (is_mul(state_d)) begin
            rs_d = wb_d ? wb_code(state_d) : 3'b000;
        end else begin
            rs_d = fixed_rs(state_d);
        end
        m_start_d = is_mul(state_d) && !wb_d;
        busy_d    = (state_d != IDLE) && (state_d != DONE);
        done_d    = (state_d == DONE);
        err_d     = (state_d == DONE) && zero_d;
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            k_q       <= '0;
            idx_q     <= IDX_TOP;
            lead0_q   <= 1'b0;
            wb_q      <= 1'b0;
            zero_q    <= 1'b0;
`ifdef ECC_LADDER_CONST_TIME_EN
            found_q   <= 1'b0;
            lead_q    <= '0;
`endif
            cw_q      <= '0;
            rs_q      <= '0;
            m_start_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            idx_q     <= idx_d;
            lead0_q   <= lead0_d;
            wb_q      <= wb_d;
            zero_q    <= zero_d;
`ifdef ECC_LADDER_CONST_TIME_EN
            found_q   <= found_d;
            lead_q    <= lead_d;
`endif
            cw_q      <= cw_d;
            rs_q      <= rs_d;
            m_start_q <= m_start_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.select_x   = cw_q[6];
    assign bus.select_xab = cw_q[5];
    assign bus.select_z   = cw_q[4];
    assign bus.select_zab = cw_q[3];
    assign bus.ss         = cw_q[2];
    assign bus.st         = cw_q[1];
    assign bus.sy         = cw_q[0];
    assign bus.reg_select = rs_q;
    assign bus.m_start    = m_start_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

endmodule
